// File: rtl/dma_pkg.sv
// dma_pkg: shared arbiter state encoding and DMA burst constants
package dma_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DRAIN   = 3'd2,
    GRANT   = 3'd3,
    WAITINT = 3'd4,
    ABORT   = 3'd5
  } state_t;
  localparam int WORD_SIZE = 16;
  localparam int BURST_BLOCKS = 3;
  localparam int BURST_WORDS = 4;
  localparam logic [WORD_SIZE-1:0] BURST_BASE = 16'h1f4;
  function automatic int burst_len();
    return BURST_BLOCKS * BURST_WORDS;
  endfunction
endpackage

// File: rtl/grant_timer.sv
// grant_timer: counts grant cycles, flags the last cycle before timeout
module grant_timer #(
  parameter int MAX = 64,
  parameter int W = (MAX > 2) ? $clog2(MAX) : 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  end
  assign o_tc = r_cnt == W'(MAX - 1);
endmodule

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: sequences one DMA transfer and arbitrates the memory bus between CPU and DMA
module dma_bus_arbiter
  import dma_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 64,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             dma_start,
  input  logic             cpu_mem_busy,
  input  logic             BR,
  input  logic             dma_interrupt,
  output logic             cmd,
  output logic             BG,
  output logic             cpu_bus_hold,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [CNT_W-1:0] burst_count
);
  state_t r_state, w_next;
  logic r_int_seen, w_tc, w_retire;
  grant_timer #(.MAX(GRANT_TIMEOUT)) u_timer (
    .i_clk  (CLK),
    .i_rst_n(reset_n),
    .i_clr  (r_state != GRANT),
    .i_en   (r_state == GRANT),
    .o_tc   (w_tc)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = dma_start ? CMD : IDLE;
      CMD:     w_next = BR ? DRAIN : CMD;
      DRAIN:   w_next = cpu_mem_busy ? DRAIN : GRANT;
      GRANT:   w_next = !BR ? WAITINT : (w_tc ? ABORT : GRANT);
      WAITINT: w_next = (dma_interrupt || r_int_seen) ? IDLE : WAITINT;
      ABORT:   w_next = BR ? ABORT : IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign w_retire = (r_state == WAITINT) && (w_next == IDLE);
  // an interrupt landing while still in GRANT is remembered so WAITINT retires at once
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_int_seen   <= 1'b0;
      cmd          <= 1'b0;
      BG           <= 1'b0;
      cpu_bus_hold <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_timeout  <= 1'b0;
      burst_count  <= '0;
    end else begin
      r_state      <= w_next;
      r_int_seen   <= (r_state == GRANT) ? (r_int_seen | dma_interrupt) : ((r_state == WAITINT) & r_int_seen);
      cmd          <= w_next inside {CMD, DRAIN, GRANT};
      BG           <= w_next == GRANT;
      cpu_bus_hold <= w_next inside {DRAIN, GRANT, ABORT};
      busy         <= w_next != IDLE;
      done         <= w_retire;
      err_timeout  <= err_timeout | (w_next == ABORT);
      burst_count  <= burst_count + {{(CNT_W-1){1'b0}}, w_retire};
    end
  end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: two arbiter instances (long/short timeout) against a flag-based transfer model
module tb_dma_bus_arbiter;
  logic CLK = 0, rst_n = 0, start = 0, mbusy = 0, br = 0, intr = 0;
  logic a_cmd, a_bg, a_hold, a_busy, a_done, a_err;
  logic b_cmd, b_bg, b_hold, b_busy, b_done, b_err;
  logic [15:0] a_cnt;
  logic [3:0] b_cnt;
  int n_pass = 0, n_tot = 0;
  int bg_hi_a = 0, bg_hi_b = 0, done_a = 0, done_b = 0;
  always #5 CLK = ~CLK;
  dma_bus_arbiter #(.GRANT_TIMEOUT(64), .CNT_W(16)) u_a (
    .CLK(CLK), .reset_n(rst_n), .dma_start(start), .cpu_mem_busy(mbusy), .BR(br),
    .dma_interrupt(intr), .cmd(a_cmd), .BG(a_bg), .cpu_bus_hold(a_hold), .busy(a_busy),
    .done(a_done), .err_timeout(a_err), .burst_count(a_cnt));
  dma_bus_arbiter #(.GRANT_TIMEOUT(8), .CNT_W(4)) u_b (
    .CLK(CLK), .reset_n(rst_n), .dma_start(start), .cpu_mem_busy(mbusy), .BR(br),
    .dma_interrupt(intr), .cmd(b_cmd), .BG(b_bg), .cpu_bus_hold(b_hold), .busy(b_busy),
    .done(b_done), .err_timeout(b_err), .burst_count(b_cnt));
  typedef struct {
    bit act, cmd, bg, hold, done, err, ab, wt, iseen;
    int gc, cnt;
  } mdl_t;
  mdl_t m[2];
  task automatic chk(string tag, int got, int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask
  // one transfer expressed as flags: active, granted, waiting for irq, aborted
  function automatic mdl_t step(mdl_t s, int t, int msk);
    mdl_t n = s;
    n.done = 0;
    if (!rst_n) return '{default: 0};
    if (!s.act) begin
      if (start) begin n.act = 1; n.cmd = 1; end
    end else if (s.ab) begin
      if (!br) begin n.act = 0; n.hold = 0; n.ab = 0; end
    end else if (s.wt) begin
      if (intr || s.iseen) begin
        n.act = 0; n.wt = 0; n.iseen = 0; n.done = 1; n.cnt = (s.cnt + 1) & msk;
      end
    end else if (s.bg) begin
      n.iseen = s.iseen | intr;
      if (!br) begin n.bg = 0; n.cmd = 0; n.hold = 0; n.wt = 1; end
      else if (s.gc == t - 1) begin n.bg = 0; n.cmd = 0; n.err = 1; n.ab = 1; n.iseen = 0; end
      else n.gc = s.gc + 1;
    end else if (s.hold) begin
      if (!mbusy) begin n.bg = 1; n.gc = 0; end
    end else if (br) n.hold = 1;
    return n;
  endfunction
  task automatic cycle();
    @(posedge CLK);
    m[0] = step(m[0], 64, 16'hffff);
    m[1] = step(m[1], 8, 15);
    #1;
    chk("a_cmd", a_cmd, m[0].cmd);   chk("b_cmd", b_cmd, m[1].cmd);
    chk("a_bg", a_bg, m[0].bg);      chk("b_bg", b_bg, m[1].bg);
    chk("a_hold", a_hold, m[0].hold); chk("b_hold", b_hold, m[1].hold);
    chk("a_busy", a_busy, m[0].act); chk("b_busy", b_busy, m[1].act);
    chk("a_done", a_done, m[0].done); chk("b_done", b_done, m[1].done);
    chk("a_err", a_err, m[0].err);   chk("b_err", b_err, m[1].err);
    chk("a_cnt", a_cnt, m[0].cnt);   chk("b_cnt", b_cnt, m[1].cnt);
    if (a_bg) bg_hi_a++;
    if (b_bg) bg_hi_b++;
    if (a_done) done_a++;
    if (b_done) done_b++;
  endtask
  task automatic do_reset();
    rst_n = 0; cycle(); rst_n = 1; cycle();
  endtask
  task automatic xfer(int busy_n, int glen, bit same, bit rst_mid, bit dbl);
    int w = 0;
    bg_hi_a = 0; bg_hi_b = 0; done_a = 0; done_b = 0;
    start = 1; cycle(); start = dbl; cycle(); start = 0; cycle();
    br = 1; mbusy = busy_n > 0;
    for (int i = 0; i < busy_n; i++) begin
      cycle();
      chk("drain_bg", a_bg, 0);
      chk("drain_hold", a_hold, 1);
    end
    mbusy = 0;
    while (!m[0].bg && w < 20) begin cycle(); w++; end
    chk("bg_lat", busy_n + w, busy_n == 0 ? 2 : busy_n + 1);
    if (rst_mid) begin
      rst_n = 0; cycle();
      chk("rst_bg", a_bg, 0); chk("rst_cmd", a_cmd, 0); chk("rst_hold", a_hold, 0);
      chk("rst_busy", a_busy, 0); chk("rst_cnt", a_cnt, 0); chk("rst_done", a_done, 0);
      rst_n = 1; br = 0; cycle();
      return;
    end
    repeat (glen - 1) cycle();
    br = 0; intr = same; cycle(); intr = 0;
    if (!same) begin cycle(); intr = 1; cycle(); intr = 0; end
    cycle(); cycle();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    repeat (3) cycle();
    chk("reset_cnt", a_cnt, 0);
    rst_n = 1; cycle();
    xfer(0, 12, 0, 0, 0);
    chk("t1_bglen", bg_hi_a, 12); chk("t1_done", done_a, 1); chk("t1_cnt", a_cnt, 1);
    chk("t1_b_bglen", bg_hi_b, 8); chk("t1_b_err", b_err, 1); chk("t1_b_done", done_b, 0);
    xfer(5, 4, 1, 0, 0);
    chk("t2_bglen", bg_hi_a, 4); chk("t2_cnt", a_cnt, 2);
    do_reset();
    xfer(0, 20, 0, 0, 0);
    chk("t3_b_bglen", bg_hi_b, 8); chk("t3_b_err", b_err, 1); chk("t3_b_done", done_b, 0);
    chk("t3_a_err", a_err, 0); chk("t3_a_done", done_a, 1);
    xfer(1, 3, 0, 0, 1);
    chk("t4_cnt", a_cnt, 2); chk("t4_done", done_a, 1);
    intr = 1; cycle(); intr = 0;
    chk("t4_idle_int", a_done, 0); cycle();
    chk("t4_cnt_after", a_cnt, 2);
    xfer(0, 5, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("t6_pre_wrap", b_cnt, 15);
      xfer(i % 3, 3, i[0], 0, 0);
    end
    chk("t6_wrap_b", b_cnt, 0); chk("t6_a_cnt", a_cnt, 16);
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      start = $urandom_range(0, 7) == 0;
      mbusy = $urandom_range(0, 2) == 0;
      if ($urandom_range(0, 5) == 0) br = ~br;
      intr = $urandom_range(0, 9) == 0;
      cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
